// File: rtl/pop_result_checker_if.sv
// pop_result_checker_if
//   Groups the trace-reader / task-generator signals that feed the pop
//   result checker.
//   push, push_tree_id : push strobe and its target tree
//   pop, pop_tree_id   : pop request strobe and the tree of the pending pop
//   pop_out, pop_data  : pop result valid and {tag, priority}
//   finish             : trace reader done (level)
//   master drives these signals (stimulus side); slave samples them (checker).
interface pop_result_checker_if #(
    parameter int PTW      = 16,
    parameter int MTW      = 2,
    parameter int TREE_NUM = 4
);
    localparam int TW = $clog2(TREE_NUM > 1 ? TREE_NUM : 2);

    logic                 push;
    logic [TW-1:0]        push_tree_id;
    logic                 pop;
    logic [TW-1:0]        pop_tree_id;
    logic                 pop_out;
    logic [MTW+PTW-1:0]   pop_data;
    logic                 finish;

    modport master (
        output push, push_tree_id, pop, pop_tree_id, pop_out, pop_data, finish
    );

    modport slave (
        input  push, push_tree_id, pop, pop_tree_id, pop_out, pop_data, finish
    );
endinterface

// File: rtl/pop_result_checker.sv
// pop_result_checker
//   Consumes the task generator's pop stream and checks every popped entry:
//   tree tag, min-priority ordering per tree, no spurious pops, no pop
//   timeout, no outstanding-pop overflow. Keeps per-tree pop counters and
//   raises a sticky PASS/FAIL verdict once finish is seen and all pops drained.
// Ports
//   i_clk, i_arst_n : clock, synchronous active-low reset
//   bus             : slave side of pop_result_checker_if (push/pop/pop_out/finish)
//   o_done          : verdict reached (PASS or FAIL)
//   o_pass          : verdict reached with no error
//   o_err_code      : first error 0 none,1 tag,2 order,3 spurious,4 timeout,5 overflow
//   o_err_tree      : tree of the first error
//   o_err_prio      : priority of the first error (0 for spurious/timeout/overflow)
//   o_pop_cnt       : per-tree pop counts, tree t at [t*CTW +: CTW]
//   o_outstanding   : pops issued and not yet returned
module pop_result_checker #(
    parameter  int PTW      = 16,
    parameter  int MTW      = 2,
    parameter  int TREE_NUM = 4,
    parameter  int CTW      = 16,
    parameter  int OST_MAX  = 8,
    parameter  int TIMEOUT  = 1024,
    localparam int TW       = $clog2(TREE_NUM > 1 ? TREE_NUM : 2),
    localparam int OCW      = $clog2(OST_MAX + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    pop_result_checker_if.slave     bus,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [2:0]              o_err_code,
    output logic [TW-1:0]           o_err_tree,
    output logic [PTW-1:0]          o_err_prio,
    output logic [TREE_NUM*CTW-1:0] o_pop_cnt,
    output logic [OCW-1:0]          o_outstanding
);
    localparam int TMW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_TAG   = 3'd1;
    localparam logic [2:0] E_ORDER = 3'd2;
    localparam logic [2:0] E_SPUR  = 3'd3;
    localparam logic [2:0] E_TMO   = 3'd4;
    localparam logic [2:0] E_OVF   = 3'd5;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_FAIL} state_e;

    state_e                       state_q, state_d;
    logic                         done_q, done_d;
    logic                         pass_q, pass_d;
    logic [2:0]                   err_code_q;
    logic [TW-1:0]                err_tree_q;
    logic [PTW-1:0]               err_prio_q;
    logic [OCW-1:0]               ost_q, ost_d;
    logic [TMW-1:0]               tmo_q, tmo_d;
    logic [TREE_NUM-1:0]          ref_vld_q, ref_vld_d;
    logic [TREE_NUM-1:0][PTW-1:0] last_prio_q, last_prio_d;
    logic [TREE_NUM-1:0][CTW-1:0] cnt_q, cnt_d;

    logic [PTW-1:0] prio;
    logic [MTW-1:0] tag;
    logic [TW-1:0]  tree;
    logic           tag_err, order_err, spur_err, tmo_err, ovf_err;
    logic [2:0]     err_code_n;
    logic [PTW-1:0] err_prio_n;
    logic           active, err_hit;

    assign prio = bus.pop_data[PTW-1:0];
    assign tag  = bus.pop_data[PTW+MTW-1:PTW];
    assign tree = bus.pop_tree_id;

    // Outstanding pop count; a pop and a return in the same cycle cancel.
    always_comb begin
        ost_d = ost_q;
        case ({bus.pop, bus.pop_out})
            2'b10:   if (ost_q != OCW'(OST_MAX)) ost_d = ost_q + 1'b1;
            2'b01:   if (ost_q != '0)            ost_d = ost_q - 1'b1;
            default: ost_d = ost_q;
        endcase
    end

    // Timeout counter idles at 0 while nothing is outstanding and restarts
    // on every return; it saturates so the error stays asserted.
    always_comb begin
        tmo_d = tmo_q;
        if (bus.pop_out || ost_q == '0)   tmo_d = '0;
        else if (tmo_q != TMW'(TIMEOUT))  tmo_d = tmo_q + 1'b1;
    end

    // Error detection. The order check reads the registered reference, so a
    // same-cycle push to the same tree does not mask the comparison.
    always_comb begin
        tag_err   = bus.pop_out && (32'(tag) != 32'(tree));
        order_err = bus.pop_out && ref_vld_q[tree] && (prio < last_prio_q[tree]);
        spur_err  = bus.pop_out && !bus.pop && (ost_q == '0);
        tmo_err   = (tmo_d == TMW'(TIMEOUT));
        ovf_err   = bus.pop && !bus.pop_out && (ost_q == OCW'(OST_MAX));
    end

    // Lowest error code wins when several fire together.
    always_comb begin
        err_code_n = E_NONE;
        err_prio_n = '0;
        if (tag_err) begin
            err_code_n = E_TAG;
            err_prio_n = prio;
        end else if (order_err) begin
            err_code_n = E_ORDER;
            err_prio_n = prio;
        end else if (spur_err) begin
            err_code_n = E_SPUR;
        end else if (tmo_err) begin
            err_code_n = E_TMO;
        end else if (ovf_err) begin
            err_code_n = E_OVF;
        end
    end

    assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign err_hit = active && (err_code_n != E_NONE);

    // Per-tree reference and counters. A push invalidates the reference
    // because a newly pushed entry may legitimately pop ahead of the last one;
    // a return to the same tree in the same cycle reloads it.
    always_comb begin
        ref_vld_d   = ref_vld_q;
        last_prio_d = last_prio_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < TREE_NUM; i++) begin
            if (bus.push && bus.push_tree_id == TW'(i)) ref_vld_d[i] = 1'b0;
            if (bus.pop_out && tree == TW'(i)) begin
                ref_vld_d[i]   = 1'b1;
                last_prio_d[i] = prio;
                if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) state_q <= S_RUN;
        else           state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (err_hit)         state_d = S_FAIL;
                else if (bus.finish) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (err_hit)          state_d = S_FAIL;
                else if (ost_q == '0) state_d = S_DONE;
            end
            default: state_d = state_q;
        endcase
    end

    // FSM: outputs, decoded from the next state and registered below so the
    // verdict appears the cycle after its condition is sampled.
    always_comb begin
        done_d = (state_d == S_DONE) || (state_d == S_FAIL);
        pass_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_code_q  <= E_NONE;
            err_tree_q  <= '0;
            err_prio_q  <= '0;
            ost_q       <= '0;
            tmo_q       <= '0;
            ref_vld_q   <= '0;
            last_prio_q <= '0;
            cnt_q       <= '0;
        end else begin
            done_q      <= done_d;
            pass_q      <= pass_d;
            ost_q       <= ost_d;
            tmo_q       <= tmo_d;
            ref_vld_q   <= ref_vld_d;
            last_prio_q <= last_prio_d;
            cnt_q       <= cnt_d;
            if (err_hit) begin
                err_code_q <= err_code_n;
                err_tree_q <= tree;
                err_prio_q <= err_prio_n;
            end
        end
    end

    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_err_code    = err_code_q;
    assign o_err_tree    = err_tree_q;
    assign o_err_prio    = err_prio_q;
    assign o_pop_cnt     = cnt_q;
    assign o_outstanding = ost_q;
endmodule

// File: tb/tb_pop_result_checker.sv
// tb_pop_result_checker
//   Directed bench: expected verdict fields are queued as stimulus is driven
//   and compared once the registered outputs update; pop counts and the
//   outstanding count come from a small bench model.
module tb_pop_result_checker;
    localparam int PTW = 16, MTW = 2, TREE_NUM = 4, CTW = 16, OST_MAX = 8, TIMEOUT = 1024;
    localparam int TW = 2, OCW = 4;

    localparam int K_DONE = 0, K_PASS = 1, K_CODE = 2, K_TREE = 3, K_PRIO = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    done, pass;
    logic [2:0]              err_code;
    logic [TW-1:0]           err_tree;
    logic [PTW-1:0]          err_prio;
    logic [TREE_NUM*CTW-1:0] pop_cnt;
    logic [OCW-1:0]          outstanding;

    pop_result_checker_if #(.PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM)) bus ();

    pop_result_checker #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .CTW(CTW),
        .OST_MAX(OST_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .bus          (bus.slave),
        .o_done       (done),
        .o_pass       (pass),
        .o_err_code   (err_code),
        .o_err_tree   (err_tree),
        .o_err_prio   (err_prio),
        .o_pop_cnt    (pop_cnt),
        .o_outstanding(outstanding)
    );

    typedef struct {
        string tag;
        int    kind;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   m_cnt[TREE_NUM];
    int   m_ost;

    function automatic int observe(int kind);
        case (kind)
            K_DONE:  return int'(done);
            K_PASS:  return int'(pass);
            K_CODE:  return int'(err_code);
            K_TREE:  return int'(err_tree);
            K_PRIO:  return int'(err_prio);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_v(input string tag, input int kind, input int val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_verdict(input string tag, input int d, input int p, input int c);
        expect_v({tag, "_done"}, K_DONE, d);
        expect_v({tag, "_pass"}, K_PASS, p);
        expect_v({tag, "_code"}, K_CODE, c);
    endtask

    task automatic resolve();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CTW-1:0] c;
        for (int t = 0; t < TREE_NUM; t++) begin
            c = pop_cnt[t*CTW +: CTW];
            check($sformatf("%s_cnt%0d", tag, t), int'(c), m_cnt[t]);
        end
        check({tag, "_ost"}, int'(outstanding), m_ost);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One cycle of stimulus; the model tracks what the counters should show.
    task automatic drive(input logic p, input int pt, input logic po, input int tg,
                         input int pr, input logic pu, input int put);
        bus.pop          = p;
        bus.pop_tree_id  = TW'(pt);
        bus.pop_out      = po;
        bus.pop_data     = {MTW'(tg), PTW'(pr)};
        bus.push         = pu;
        bus.push_tree_id = TW'(put);
        if (po) m_cnt[pt]++;
        if (p && !po && m_ost < OST_MAX) m_ost++;
        else if (po && !p && m_ost > 0) m_ost--;
        step();
        bus.pop     = 1'b0;
        bus.pop_out = 1'b0;
        bus.push    = 1'b0;
    endtask

    task automatic pop_req(input int t);
        drive(1'b1, t, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic pop_ret(input int t, input int tg, input int pr);
        drive(1'b0, t, 1'b1, tg, pr, 1'b0, 0);
    endtask

    task automatic do_reset(input string tag);
        arst_n     = 1'b0;
        bus.finish = 1'b0;
        bus.pop = 1'b0; bus.pop_out = 1'b0; bus.push = 1'b0;
        bus.pop_tree_id = '0; bus.push_tree_id = '0; bus.pop_data = '0;
        step();
        step();
        for (int t = 0; t < TREE_NUM; t++) m_cnt[t] = 0;
        m_ost = 0;
        expect_verdict(tag, 0, 0, 0);
        expect_v({tag, "_tree"}, K_TREE, 0);
        expect_v({tag, "_prio"}, K_PRIO, 0);
        resolve();
        check_model(tag);
        arst_n = 1'b1;
    endtask

    initial begin
        // Clean run on tree 1: non-decreasing priorities then finish.
        do_reset("rst0");
        for (int i = 0; i < 3; i++) begin
            pop_req(1);
            pop_ret(1, 1, (i == 0) ? 5 : 7);
        end
        bus.finish = 1'b1;
        step();
        expect_verdict("t1_drain", 0, 0, 0);
        resolve();
        step();
        expect_verdict("t1_done", 1, 1, 0);
        resolve();
        check_model("t1");

        // Order violation on tree 2, then counting continues in FAIL.
        do_reset("rst1");
        pop_req(2);
        pop_ret(2, 2, 9);
        expect_verdict("t2_ok", 0, 0, 0);
        resolve();
        pop_req(2);
        pop_ret(2, 2, 4);
        expect_verdict("t2_order", 1, 0, 2);
        expect_v("t2_tree", K_TREE, 2);
        expect_v("t2_prio", K_PRIO, 4);
        resolve();
        pop_req(2);
        pop_ret(2, 2, 10);
        expect_v("t2_frozen_code", K_CODE, 2);
        expect_v("t2_frozen_prio", K_PRIO, 4);
        resolve();
        check_model("t2");

        // Push between pops resets the ordering reference.
        do_reset("rst2");
        pop_req(0);
        pop_ret(0, 0, 9);
        drive(1'b0, 0, 1'b0, 0, 0, 1'b1, 0);
        pop_req(0);
        pop_ret(0, 0, 4);
        expect_verdict("t3_push", 0, 0, 0);
        resolve();
        check_model("t3");
        // Same-cycle push and return: the check still uses the old reference.
        pop_req(0);
        drive(1'b0, 0, 1'b1, 0, 3, 1'b1, 0);
        expect_verdict("t3_same", 1, 0, 2);
        expect_v("t3_same_prio", K_PRIO, 3);
        resolve();

        // Spurious return with nothing outstanding.
        do_reset("rst3");
        pop_ret(2, 2, 7);
        expect_verdict("t4_spur", 1, 0, 3);
        expect_v("t4_spur_prio", K_PRIO, 0);
        resolve();
        check_model("t4");

        // Timeout: exactly TIMEOUT cycles of waiting trips the error.
        do_reset("rst4");
        pop_req(1);
        idle(TIMEOUT - 1);
        expect_verdict("t4_tmo_before", 0, 0, 0);
        resolve();
        idle(1);
        expect_verdict("t4_tmo", 1, 0, 4);
        resolve();

        // Tag and order both bad: tag error has priority.
        do_reset("rst5");
        pop_req(1);
        pop_ret(1, 1, 9);
        pop_req(1);
        pop_ret(1, 3, 4);
        expect_verdict("t5_tag", 1, 0, 1);
        expect_v("t5_tree", K_TREE, 1);
        expect_v("t5_prio", K_PRIO, 4);
        resolve();

        // Overflow at OST_MAX; pop+return in one cycle leaves the count alone.
        do_reset("rst6");
        for (int i = 0; i < OST_MAX; i++) pop_req(0);
        check_model("t6_full");
        drive(1'b1, 0, 1'b1, 0, 1, 1'b0, 0);
        expect_verdict("t6_both", 0, 0, 0);
        resolve();
        check_model("t6_both");
        pop_req(0);
        expect_verdict("t6_ovf", 1, 0, 5);
        expect_v("t6_ovf_prio", K_PRIO, 0);
        resolve();
        check_model("t6_ovf");

        // Finish with two outstanding: verdict waits for the drain.
        do_reset("rst7");
        pop_req(3);
        pop_req(3);
        bus.finish = 1'b1;
        idle(4);
        expect_verdict("t7_wait", 0, 0, 0);
        resolve();
        check_model("t7_wait");
        pop_ret(3, 3, 2);
        expect_verdict("t7_one", 0, 0, 0);
        resolve();
        pop_ret(3, 3, 6);
        expect_verdict("t7_two", 0, 0, 0);
        resolve();
        step();
        expect_verdict("t7_done", 1, 1, 0);
        resolve();
        check_model("t7_done");

        // Reset in the middle of DRAIN discards everything.
        do_reset("rst8");
        pop_req(2);
        pop_req(2);
        pop_ret(2, 2, 1);
        bus.finish = 1'b1;
        idle(3);
        expect_verdict("t8_drain", 0, 0, 0);
        resolve();
        check_model("t8_drain");
        do_reset("t8_rst");
        idle(3);
        expect_verdict("t8_run", 0, 0, 0);
        resolve();
        check_model("t8_run");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
